// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default sizing for the hazard scoreboard slice.
//   result_class_t : class of an instruction's rd result (ALU, PC4, IMM, LOAD)
//   *_DEFAULT      : default XLEN / NUM_REGS / DEPTH / LOAD_STAGE values
package hazard_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam int unsigned NUM_REGS_DEFAULT   = 16;
  localparam int unsigned DEPTH_DEFAULT      = 4;
  localparam int unsigned LOAD_STAGE_DEFAULT = 3;

  typedef enum logic [1:0] {
    ALU  = 2'd0,
    PC4  = 2'd1,
    IMM  = 2'd2,
    LOAD = 2'd3
  } result_class_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bus between the ID stage / datapath and the hazard scoreboard.
//   master : drives the ID instruction fields, flush, ext_stall and the
//            per-stage results; receives resolved operands and stall info.
//   slave  : the scoreboard side (directions reversed).
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned RA_W  = $clog2(NUM_REGS_DEFAULT),
  parameter int unsigned DEPTH = DEPTH_DEFAULT
);

  logic                            id_valid;
  logic [RA_W-1:0]                 id_rs1;
  logic [RA_W-1:0]                 id_rs2;
  logic                            id_rs1_used;
  logic                            id_rs2_used;
  logic [RA_W-1:0]                 id_rd;
  logic                            id_rd_we;
  result_class_t                   id_class;
  logic [XLEN-1:0]                 id_rs1_data;
  logic [XLEN-1:0]                 id_rs2_data;
  logic                            flush;
  logic                            ext_stall;
  logic [DEPTH-1:0][XLEN-1:0]      stage_result;

  logic [XLEN-1:0]                 rs1_data;
  logic [XLEN-1:0]                 rs2_data;
  logic                            rs1_fwd;
  logic                            rs2_fwd;
  logic                            stall;
  logic [31:0]                     stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_class, id_rs1_data, id_rs2_data,
           flush, ext_stall, stage_result,
    input  rs1_data, rs2_data, rs1_fwd, rs2_fwd, stall, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_class, id_rs1_data, id_rs2_data,
           flush, ext_stall, stage_result,
    output rs1_data, rs2_data, rs1_fwd, rs2_fwd, stall, stall_cycles
  );

endinterface

// File: rtl/hazard_operand_lookup.sv
// Per-operand priority search over the in-flight entry array.
//   ent_*        : entry array state (index 0 = EX, DEPTH-1 = WB)
//   rs, rs_used  : source address and whether it is actually read
//   rf_data      : register-file read data
//   stage_result : per-stage rd value from the datapath
//   data / fwd   : resolved operand and "came from stage_result" flag
//   hazard       : youngest matching producer has no data yet
module hazard_operand_lookup
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned RA_W       = $clog2(NUM_REGS_DEFAULT),
  parameter int unsigned DEPTH      = DEPTH_DEFAULT,
  parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEFAULT
) (
  input  logic [DEPTH-1:0]            ent_valid,
  input  logic [DEPTH-1:0]            ent_we,
  input  logic [DEPTH-1:0][RA_W-1:0]  ent_rd,
  input  result_class_t [DEPTH-1:0]   ent_cls,
  input  logic [RA_W-1:0]             rs,
  input  logic                        rs_used,
  input  logic [XLEN-1:0]             rf_data,
  input  logic [DEPTH-1:0][XLEN-1:0]  stage_result,
  output logic [XLEN-1:0]             data,
  output logic                        fwd,
  output logic                        hazard
);

  always_comb begin
    logic found;
    found  = 1'b0;
    data   = rf_data;
    fwd    = 1'b0;
    hazard = 1'b0;
    // Ascending scan with a found flag: the youngest (lowest index) match wins.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && ent_valid[i] && ent_we[i] && (ent_rd[i] == rs) &&
          (rs != '0) && rs_used) begin
        found = 1'b1;
        if ((ent_cls[i] != LOAD) || (i >= LOAD_STAGE)) begin
          data = stage_result[i];
          fwd  = 1'b1;
        end else begin
          hazard = 1'b1;
        end
      end
    end
    // x0 is hardwired; the rs != 0 term above already keeps fwd/hazard low.
    if (rs == '0) data = '0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks rd writes of DEPTH post-ID stages,
// forwards ready results to the ID operands and stalls IF/ID on load-use
// or external hazards.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : hazard_scoreboard_if slave (ID fields, flush, ext_stall,
//              stage_result in; rs*_data, rs*_fwd, stall, stall_cycles out)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEFAULT,
  parameter int unsigned RA_W       = $clog2(NUM_REGS),
  parameter int unsigned DEPTH      = DEPTH_DEFAULT,
  parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave bus
);

  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0]            ent_we;
  logic [DEPTH-1:0][RA_W-1:0]  ent_rd;
  result_class_t [DEPTH-1:0]   ent_cls;
  logic [31:0]                 stall_cnt;

  logic rs1_hazard;
  logic rs2_hazard;
  logic stall;
  logic issue;

  hazard_operand_lookup #(
    .XLEN       (XLEN),
    .RA_W       (RA_W),
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_rs1_lookup (
    .ent_valid    (ent_valid),
    .ent_we       (ent_we),
    .ent_rd       (ent_rd),
    .ent_cls      (ent_cls),
    .rs           (bus.id_rs1),
    .rs_used      (bus.id_rs1_used),
    .rf_data      (bus.id_rs1_data),
    .stage_result (bus.stage_result),
    .data         (bus.rs1_data),
    .fwd          (bus.rs1_fwd),
    .hazard       (rs1_hazard)
  );

  hazard_operand_lookup #(
    .XLEN       (XLEN),
    .RA_W       (RA_W),
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_rs2_lookup (
    .ent_valid    (ent_valid),
    .ent_we       (ent_we),
    .ent_rd       (ent_rd),
    .ent_cls      (ent_cls),
    .rs           (bus.id_rs2),
    .rs_used      (bus.id_rs2_used),
    .rf_data      (bus.id_rs2_data),
    .stage_result (bus.stage_result),
    .data         (bus.rs2_data),
    .fwd          (bus.rs2_fwd),
    .hazard       (rs2_hazard)
  );

  // Flush wins over any hazard: the ID instruction is squashed, not held.
  assign stall = ~bus.flush & bus.id_valid & (rs1_hazard | rs2_hazard | bus.ext_stall);
  assign issue = bus.id_valid & ~stall & ~bus.flush;

  assign bus.stall        = stall;
  assign bus.stall_cycles = stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      ent_we    <= '0;
      ent_rd    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_cls[i] <= ALU;
      stall_cnt <= '0;
    end else begin
      // Loop form keeps DEPTH=1 legal (no [DEPTH-2:0] slice).
      for (int unsigned i = 1; i < DEPTH; i++) begin
        ent_valid[i] <= ent_valid[i-1];
        ent_we[i]    <= ent_we[i-1];
        ent_rd[i]    <= ent_rd[i-1];
        ent_cls[i]   <= ent_cls[i-1];
      end
      ent_valid[0] <= issue;
      ent_we[0]    <= bus.id_rd_we;
      ent_rd[0]    <= bus.id_rd;
      ent_cls[0]   <= bus.id_class;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam logic [31:0] RF1 = 32'h1111_1111;
  localparam logic [31:0] RF2 = 32'h2222_2222;

  typedef struct {
    logic                 valid;
    logic [3:0]           rs1, rs2;
    logic                 u1, u2;
    logic [3:0]           rd;
    logic                 we;
    result_class_t        cls;
    logic                 flush, xs;
    logic [3:0][31:0]     sr;
  } stim_t;

  typedef struct {
    int          id;
    logic [31:0] r1;
    logic        f1;
    logic [31:0] r2;
    logic        f2;
    logic        st;
    logic [31:0] cnt;
    bit          dc1;   // rs1 value/flag unspecified (hazard cycle)
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.XLEN(32), .RA_W(4), .DEPTH(4)) bus ();

  hazard_scoreboard #(
    .XLEN(32), .NUM_REGS(16), .RA_W(4), .DEPTH(4), .LOAD_STAGE(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic stim_t nop();
    stim_t s;
    s.valid = 1'b0; s.rs1 = '0; s.rs2 = '0; s.u1 = 1'b0; s.u2 = 1'b0;
    s.rd = '0; s.we = 1'b0; s.cls = ALU; s.flush = 1'b0; s.xs = 1'b0;
    for (int i = 0; i < 4; i++) s.sr[i] = 32'hC0DE_0000 | 32'(i);
    return s;
  endfunction

  function automatic exp_t E(int id, logic [31:0] r1, logic f1, logic [31:0] r2,
                             logic f2, logic st, logic [31:0] cnt, bit dc1);
    exp_t e;
    e.id = id; e.r1 = r1; e.f1 = f1; e.r2 = r2; e.f2 = f2;
    e.st = st; e.cnt = cnt; e.dc1 = dc1;
    return e;
  endfunction

  task automatic drive(input logic r, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst                  = r;
    bus.id_valid         = s.valid;
    bus.id_rs1           = s.rs1;
    bus.id_rs2           = s.rs2;
    bus.id_rs1_used      = s.u1;
    bus.id_rs2_used      = s.u2;
    bus.id_rd            = s.rd;
    bus.id_rd_we         = s.we;
    bus.id_class         = s.cls;
    bus.id_rs1_data      = RF1;
    bus.id_rs2_data      = RF2;
    bus.flush            = s.flush;
    bus.ext_stall        = s.xs;
    bus.stage_result     = s.sr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int id0, input int n, input logic [31:0] cnt);
    for (int k = 0; k < n; k++) drive(1'b0, nop(), E(id0 + k, '0, 1'b0, '0, 1'b0, 1'b0, cnt, 1'b0));
  endtask

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, expv);
    end
  endtask

  // Monitor: compares the combinational outputs mid-cycle against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.dc1) begin
          chk(e.id, "rs1_data", bus.rs1_data, e.r1);
          chk(e.id, "rs1_fwd", 32'(bus.rs1_fwd), 32'(e.f1));
        end
        chk(e.id, "rs2_data", bus.rs2_data, e.r2);
        chk(e.id, "rs2_fwd", 32'(bus.rs2_fwd), 32'(e.f2));
        chk(e.id, "stall", 32'(bus.stall), 32'(e.st));
        chk(e.id, "stall_cycles", bus.stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_rd = '0;
    bus.id_rd_we = 1'b0; bus.id_class = ALU; bus.id_rs1_data = RF1;
    bus.id_rs2_data = RF2; bus.flush = 1'b0; bus.ext_stall = 1'b0;
    bus.stage_result = '0;

    // Held in reset: no entries captured, RF data passes through.
    s = nop(); s.valid = 1; s.rs1 = 5; s.u1 = 1; s.rd = 5; s.we = 1;
    drive(1'b1, s, E(0, RF1, 0, '0, 0, 0, 0, 0));

    // addi x5 then consumer of x5 forwarded from EX
    s = nop(); s.valid = 1; s.rs1 = 1; s.u1 = 1; s.rs2 = 3; s.rd = 5; s.we = 1;
    drive(1'b0, s, E(1, RF1, 0, RF2, 0, 0, 0, 0));
    s = nop(); s.valid = 1; s.rs1 = 5; s.u1 = 1; s.rd = 8; s.we = 1; s.sr[0] = 32'h1234;
    drive(1'b0, s, E(2, 32'h1234, 1, '0, 0, 0, 0, 0));
    idle(3, 4, 0);

    // lw x6, then a use of x6: three stall cycles then forward from WB
    s = nop(); s.valid = 1; s.rs1 = 2; s.u1 = 1; s.rd = 6; s.we = 1; s.cls = LOAD;
    drive(1'b0, s, E(10, RF1, 0, '0, 0, 0, 0, 0));
    s = nop(); s.valid = 1; s.rs1 = 6; s.u1 = 1; s.rd = 9; s.we = 1; s.sr[3] = 32'h5555_0006;
    drive(1'b0, s, E(11, '0, 0, '0, 0, 1, 0, 1));
    drive(1'b0, s, E(12, '0, 0, '0, 0, 1, 1, 1));
    drive(1'b0, s, E(13, '0, 0, '0, 0, 1, 2, 1));
    drive(1'b0, s, E(14, 32'h5555_0006, 1, '0, 0, 0, 3, 0));
    idle(15, 4, 3);

    // two in-flight writes to x7: youngest wins
    s = nop(); s.valid = 1; s.rd = 7; s.we = 1;
    drive(1'b0, s, E(20, '0, 0, '0, 0, 0, 3, 0));
    s.rd = 10;
    drive(1'b0, s, E(21, '0, 0, '0, 0, 0, 3, 0));
    s.rd = 7;
    drive(1'b0, s, E(22, '0, 0, '0, 0, 0, 3, 0));
    s = nop(); s.valid = 1; s.rs1 = 4; s.rs2 = 7; s.u2 = 1; s.sr[0] = 32'hA; s.sr[2] = 32'hB;
    drive(1'b0, s, E(23, RF1, 0, 32'hA, 1, 0, 3, 0));
    s = nop(); s.valid = 1; s.rs1 = 7; s.u1 = 1; s.rs2 = 10; s.u2 = 1;
    s.sr[1] = 32'hB1; s.sr[2] = 32'hB2;
    drive(1'b0, s, E(24, 32'hB1, 1, 32'hB2, 1, 0, 3, 0));
    idle(25, 4, 3);

    // load into x0 followed by reads of x0: never forwarded, never stalls
    s = nop(); s.valid = 1; s.rd = 0; s.we = 1; s.cls = LOAD;
    drive(1'b0, s, E(30, '0, 0, '0, 0, 0, 3, 0));
    s = nop(); s.valid = 1; s.u1 = 1; s.u2 = 1; s.sr[0] = 32'hDEAD;
    drive(1'b0, s, E(31, '0, 0, '0, 0, 0, 3, 0));
    idle(32, 4, 3);

    // load hazard with flush: no stall, no count, entry 0 bubbled
    s = nop(); s.valid = 1; s.rd = 6; s.we = 1; s.cls = LOAD;
    drive(1'b0, s, E(40, '0, 0, '0, 0, 0, 3, 0));
    s = nop(); s.valid = 1; s.rs1 = 6; s.u1 = 1; s.rd = 11; s.we = 1; s.flush = 1;
    drive(1'b0, s, E(41, '0, 0, '0, 0, 0, 3, 1));
    s = nop(); s.valid = 1; s.rs1 = 11; s.u1 = 1;
    drive(1'b0, s, E(42, RF1, 0, '0, 0, 0, 3, 0));
    s = nop(); s.valid = 1; s.rs1 = 6; s.u1 = 1;
    drive(1'b0, s, E(43, '0, 0, '0, 0, 1, 3, 1));
    // reset mid-stall: stall and counter drop in the same cycle
    drive(1'b1, s, E(44, RF1, 0, '0, 0, 0, 0, 0));

    // external stall
    s = nop(); s.valid = 1; s.xs = 1;
    drive(1'b0, s, E(50, '0, 0, '0, 0, 1, 0, 0));
    s.valid = 0;
    drive(1'b0, s, E(51, '0, 0, '0, 0, 0, 1, 0));
    drive(1'b0, nop(), E(52, '0, 0, '0, 0, 0, 1, 0));

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-002 Parameter XLEN SHALL default to 32 and SHALL set the data width.
REQ-003 Parameter NUM_REGS SHALL default to 16 (RV32E register count).
REQ-004 Parameter RA_W SHALL default to $clog2(NUM_REGS) and SHALL set the register-address width.
REQ-005 Parameter DEPTH SHALL default to 4 and SHALL set the number of tracked post-ID stages; index 0 is EX and index DEPTH-1 is WB.
REQ-006 Parameter LOAD_STAGE SHALL default to 3 and SHALL give the first stage index at which load data is valid.
REQ-007 clk  in  1  core clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 id_valid  in  1  ID holds a valid instruction.
REQ-010 id_rs1, id_rs2  in  RA_W each  source register addresses.
REQ-011 id_rs1_used, id_rs2_used  in  1 each  the source operand is actually read.
REQ-012 id_rd  in  RA_W  destination register.
REQ-013 id_rd_we  in  1  the instruction writes rd.
REQ-014 id_class  in  result_class_t  class of the rd result: ALU, PC4, IMM or LOAD.
REQ-015 id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
REQ-016 flush  in  1  a branch was taken in EX.
REQ-017 ext_stall  in  1  MMIO/SPI busy hold.
REQ-018 stage_result  in  DEPTH x XLEN  per-stage rd value from the datapath.
REQ-019 rs1_data, rs2_data  out  XLEN each  resolved operand values.
REQ-020 rs1_fwd, rs2_fwd  out  1 each  the operand came from stage_result.
REQ-021 stall  out  1  hold IF/ID this cycle.
REQ-022 stall_cycles  out  32  saturating count of stalled cycles.

Function
REQ-023 The block SHALL hold a shift array of DEPTH entries; each entry holds valid, rd, we and class, and every entry SHALL advance one index per clk unconditionally.
REQ-024 Entry 0 SHALL load {id_valid & ~stall & ~flush, id_rd, id_rd_we, id_class} each cycle; otherwise entry 0 SHALL receive a bubble (valid=0).
REQ-025 An entry at index i SHALL be "ready" when class != LOAD, or when class == LOAD and i >= LOAD_STAGE.
REQ-026 For each operand, a match at index i SHALL require: entry valid, entry we, rd equal to the source address, source address != 0, and the source used.
REQ-027 The youngest match (lowest index) SHALL win; older matches SHALL be ignored.
REQ-028 If the winning match is ready, the operand SHALL equal stage_result[i] and the fwd flag SHALL be 1.
REQ-029 If the winning match is not ready, the operand SHALL be a hazard.
REQ-030 With no match, the operand SHALL equal the register-file data and the fwd flag SHALL be 0.
REQ-031 Source register x0 SHALL always resolve to 0 and SHALL never cause a hazard.
REQ-032 stall SHALL equal ~flush & id_valid & (rs1 hazard | rs2 hazard | ext_stall); flush SHALL override stall in the same cycle.
REQ-033 Operand outputs and stall SHALL be combinational, with zero-cycle latency from the ID inputs and the entry state.
REQ-034 stall_cycles SHALL increment on every cycle with stall=1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-035 Simultaneous flush and hazard: entry 0 SHALL receive a bubble, stall SHALL be 0, and the counter SHALL NOT increment.
REQ-036 With DEPTH=1 the block SHALL still elaborate; any LOAD_STAGE >= DEPTH SHALL make a load match non-ready at every index, so the result is a stall until the load retires.

Reset
REQ-037 While rst=1, all entries SHALL be invalid and stall_cycles SHALL be 0; outputs SHALL therefore be stall=0, fwd flags=0 and operands equal to the register-file data (0 for x0).
REQ-038 Reset asserted mid-stall SHALL drop stall on the same cycle, since no entries remain valid.

Structure
REQ-039 Package hazard_pkg SHALL hold the result_class_t enum (ALU, PC4, IMM, LOAD) and the default values of XLEN, NUM_REGS and DEPTH.
REQ-040 The per-operand priority search SHALL be the sub-module hazard_operand_lookup, instantiated twice (rs1, rs2).
REQ-041 The entry array and the counter SHALL be the only state in the block.

Verification (DEPTH=4, LOAD_STAGE=3)
REQ-042 addi x5 issued, then an instruction reading x5 on the next cycle with stage_result[0]=0x1234 -> rs1_data=0x1234, rs1_fwd=1, stall=0.
REQ-043 lw x6, then an instruction reading x6 -> stall=1 for 3 cycles (entry indices 0,1,2), then stage_result[3] is forwarded; stall_cycles=3.
REQ-044 Two in-flight writes to x7 at indices 0 (0xA) and 2 (0xB) -> rs2_data=0xA.
REQ-045 Source x0 with an in-flight write to x0 -> rs1_data=0, rs1_fwd=0, stall=0.
REQ-046 Load hazard plus flush in the same cycle -> stall=0, entry 0 receives a bubble, counter unchanged; asserting rst during a load stall -> stall=0 and stall_cycles=0 immediately.
